// File: rtl/load_store_unit.sv
// Load/store unit: execute-stage requests to a word-aligned data bus with strobes, lane extraction and error reporting.
// Latency: store 2 cycles accept->rsp, load 3 cycles (zero-wait bus); errors respond in 1 cycle; bus stalls add cycles up to TIMEOUT.
// Backpressure: o_req_ready only in IDLE; bus request held stable until i_dm_ready or timeout.
module load_store_unit #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_op,
    input  logic [XLEN-1:0]   i_req_addr,
    input  logic [XLEN-1:0]   i_req_wdata,
    output logic              o_dm_valid,
    input  logic              i_dm_ready,
    output logic [XLEN-1:0]   o_dm_addr,
    output logic              o_dm_we,
    output logic [XLEN/8-1:0] o_dm_wstrb,
    output logic [XLEN-1:0]   o_dm_wdata,
    input  logic              i_dm_rvalid,
    input  logic [XLEN-1:0]   i_dm_rdata,
    output logic              o_rsp_valid,
    output logic [XLEN-1:0]   o_rsp_rdata,
    output logic [1:0]        o_rsp_err
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RSP  = 2'd3;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_MIS = 2'b01;
    localparam logic [1:0] ERR_ILL = 2'b10;
    localparam logic [1:0] ERR_TO  = 2'b11;

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [2:0]      r_op;
    logic [OFFW-1:0] r_off;

    logic [OFFW-1:0] req_off;
    logic [NB-1:0]   sz_strb;
    logic [XLEN-1:0] sz_mask;
    logic [NB-1:0]   n_wstrb;
    logic [XLEN-1:0] n_wdata;
    logic            illegal;
    logic            misal;
    logic            to_hit;
    logic [XLEN-1:0] ld_sh;
    logic [XLEN-1:0] ld_ext;

    assign req_off     = i_req_addr[OFFW-1:0];
    assign o_req_ready = (state == S_IDLE);
    assign o_dm_valid  = (state == S_REQ);
    assign o_rsp_valid = (state == S_RSP);
    assign to_hit      = (TIMEOUT > 0) && (cnt == TO_LAST);

    // Decode the incoming request: legality, alignment, strobes and shifted store data.
    always_comb begin
        illegal = (i_req_op == 3'b111) || (i_req_we && i_req_op[2]) ||
                  ((XLEN == 32) && ((i_req_op == 3'b011) || (i_req_op == 3'b110)));
        case (i_req_op[1:0])
            2'd1:    misal = i_req_addr[0];
            2'd2:    misal = |i_req_addr[1:0];
            2'd3:    misal = |i_req_addr[2:0];
            default: misal = 1'b0;
        endcase
        case (i_req_op[1:0])
            2'd0:    sz_strb = NB'(1);
            2'd1:    sz_strb = NB'(3);
            2'd2:    sz_strb = NB'(15);
            default: sz_strb = '1;
        endcase
        sz_mask = '0;
        for (int i = 0; i < NB; i++) begin
            sz_mask[8*i +: 8] = {8{sz_strb[i]}};
        end
        n_wstrb = sz_strb << req_off;
        n_wdata = (i_req_wdata & sz_mask) << {req_off, 3'b000};
    end

    // Move the addressed lanes of the bus word down to bit 0 and extend to XLEN.
    always_comb begin
        ld_sh = i_dm_rdata >> {r_off, 3'b000};
        case (r_op)
            3'b000:  ld_ext = XLEN'($signed(ld_sh[7:0]));
            3'b001:  ld_ext = XLEN'($signed(ld_sh[15:0]));
            3'b010:  ld_ext = XLEN'($signed(ld_sh[31:0]));
            3'b100:  ld_ext = XLEN'(ld_sh[7:0]);
            3'b101:  ld_ext = XLEN'(ld_sh[15:0]);
            3'b110:  ld_ext = XLEN'(ld_sh[31:0]);
            default: ld_ext = ld_sh;
        endcase
    end

    // Access sequencer: accept, drive the bus, wait for data or timeout, respond for one cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            r_op        <= '0;
            r_off       <= '0;
            o_dm_addr   <= '0;
            o_dm_we     <= 1'b0;
            o_dm_wstrb  <= '0;
            o_dm_wdata  <= '0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= ERR_OK;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        cnt         <= '0;
                        r_op        <= i_req_op;
                        r_off       <= req_off;
                        o_rsp_rdata <= '0;
                        if (illegal) begin
                            o_rsp_err <= ERR_ILL;
                            state     <= S_RSP;
                        end else if (misal) begin
                            o_rsp_err <= ERR_MIS;
                            state     <= S_RSP;
                        end else begin
                            o_rsp_err  <= ERR_OK;
                            o_dm_addr  <= {i_req_addr[XLEN-1:OFFW], OFFW'(0)};
                            o_dm_we    <= i_req_we;
                            o_dm_wstrb <= n_wstrb;
                            o_dm_wdata <= n_wdata;
                            state      <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (i_dm_ready) begin
                        state <= o_dm_we ? S_RSP : S_WAIT;
                        cnt   <= cnt + 1'b1;
                    end else if (to_hit) begin
                        o_rsp_err <= ERR_TO;
                        state     <= S_RSP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (i_dm_rvalid) begin
                        o_rsp_rdata <= ld_ext;
                        state       <= S_RSP;
                    end else if (to_hit) begin
                        o_rsp_err <= ERR_TO;
                        state     <= S_RSP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_op = '0;
    logic [63:0] addr64 = '0, wdata64 = '0, rdata64 = '0;
    logic        dm_ready = 1'b0, dm_rvalid = 1'b0;
    logic        sel = 1'b0;

    logic        a_ready, a_dmv, a_we, a_rspv;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_strb;
    logic [1:0]  a_err;
    logic        b_ready, b_dmv, b_we, b_rspv;
    logic [63:0] b_addr, b_wdata, b_rdata;
    logic [7:0]  b_strb;
    logic [1:0]  b_err;

    logic        m_ready, m_dmv, m_we, m_rspv;
    logic [63:0] m_addr, m_wdata, m_rdata;
    logic [7:0]  m_strb;
    logic [1:0]  m_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32), .TIMEOUT(16)) u32 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(a_valid), .o_req_ready(a_ready),
        .i_req_we(req_we), .i_req_op(req_op), .i_req_addr(addr64[31:0]), .i_req_wdata(wdata64[31:0]),
        .o_dm_valid(a_dmv), .i_dm_ready(dm_ready), .o_dm_addr(a_addr), .o_dm_we(a_we),
        .o_dm_wstrb(a_strb), .o_dm_wdata(a_wdata), .i_dm_rvalid(dm_rvalid), .i_dm_rdata(rdata64[31:0]),
        .o_rsp_valid(a_rspv), .o_rsp_rdata(a_rdata), .o_rsp_err(a_err)
    );

    load_store_unit #(.XLEN(64), .TIMEOUT(4)) u64 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(b_valid), .o_req_ready(b_ready),
        .i_req_we(req_we), .i_req_op(req_op), .i_req_addr(addr64), .i_req_wdata(wdata64),
        .o_dm_valid(b_dmv), .i_dm_ready(dm_ready), .o_dm_addr(b_addr), .o_dm_we(b_we),
        .o_dm_wstrb(b_strb), .o_dm_wdata(b_wdata), .i_dm_rvalid(dm_rvalid), .i_dm_rdata(rdata64),
        .o_rsp_valid(b_rspv), .o_rsp_rdata(b_rdata), .o_rsp_err(b_err)
    );

    // View of whichever instance is currently under test, widened to 64 bits.
    always_comb begin
        if (sel) begin
            m_ready = b_ready; m_dmv = b_dmv; m_we = b_we; m_rspv = b_rspv;
            m_addr = b_addr; m_wdata = b_wdata; m_rdata = b_rdata; m_strb = b_strb; m_err = b_err;
        end else begin
            m_ready = a_ready; m_dmv = a_dmv; m_we = a_we; m_rspv = a_rspv;
            m_addr = {32'h0, a_addr}; m_wdata = {32'h0, a_wdata}; m_rdata = {32'h0, a_rdata};
            m_strb = {4'h0, a_strb}; m_err = a_err;
        end
    end

    // Reference: access size in bytes, lane offset, then plain arithmetic on bytes.
    function automatic void model(input int xl, input bit we, input logic [2:0] op,
                                  input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                                  output logic [1:0] err, output logic [7:0] strb,
                                  output logic [63:0] wdat, output logic [63:0] rdat, output logic [63:0] daddr);
        int nb, bpw, off;
        logic [63:0] xm, sm, t;
        bpw = xl / 8;
        nb  = 1 << op[1:0];
        off = int'(addr % bpw);
        xm  = (xl == 64) ? '1 : 64'hFFFF_FFFF;
        sm  = (nb == 8) ? '1 : ((64'h1 << (8 * nb)) - 64'h1);
        if (op == 3'd7 || (xl == 32 && (op == 3'd3 || op == 3'd6)) || (we && op >= 3'd4)) err = 2'd2;
        else if (addr % nb != 0) err = 2'd1;
        else err = 2'd0;
        strb  = 8'(((1 << nb) - 1) << off);
        wdat  = ((wd & sm) << (8 * off)) & xm;
        daddr = (addr - 64'(off)) & xm;
        t = ((rd & xm) >> (8 * off)) & sm;
        if (!op[2] && nb < 8 && t[8*nb-1]) t = t | ~sm;
        rdat = t & xm;
    endfunction

    // One access on instance s; starts and ends on a falling edge with the DUT idle.
    task automatic txn(input bit s, input bit we, input logic [2:0] op, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [63:0] rd, input int rdly, input int vdly,
                       input string name);
        logic [1:0] e_err; logic [7:0] e_strb; logic [63:0] e_wd, e_rd, e_addr;
        int xl, to, e_lat, cyc, reqc, waitc, dmv;
        bit hs, done;
        xl = s ? 64 : 32;
        to = s ? 4 : 16;
        model(xl, we, op, addr, wd, rd, e_err, e_strb, e_wd, e_rd, e_addr);
        if (e_err != 2'd0) begin
            e_lat = 1;
        end else if ((we && rdly >= to) || (!we && rdly + 1 + vdly >= to)) begin
            e_err = 2'd3;
            e_lat = to + 1;
        end else begin
            e_lat = we ? 2 + rdly : 3 + rdly + vdly;
        end
        if (we || e_err != 2'd0) e_rd = '0;

        sel = s; #1;
        n_tests++;
        if (m_ready !== 1'b1) begin n_fail++; $display("FAIL %s req_ready got %b exp 1", name, m_ready); end
        req_we = we; req_op = op; addr64 = addr; wdata64 = wd; rdata64 = rd;
        a_valid = !s; b_valid = s;
        @(posedge clk);
        cyc = 0; reqc = 0; waitc = 0; dmv = 0; hs = 0; done = 0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            a_valid = 1'b0; b_valid = 1'b0; dm_ready = 1'b0; dm_rvalid = 1'b0;
            if (m_rspv) begin
                done = 1;
                n_tests++;
                if (cyc != e_lat) begin n_fail++; $display("FAIL %s latency got %0d exp %0d", name, cyc, e_lat); end
                n_tests++;
                if (m_err !== e_err) begin n_fail++; $display("FAIL %s err got %b exp %b", name, m_err, e_err); end
                n_tests++;
                if (m_rdata !== e_rd) begin n_fail++; $display("FAIL %s rdata got %h exp %h", name, m_rdata, e_rd); end
                n_tests++;
                if (m_dmv !== 1'b0) begin n_fail++; $display("FAIL %s dm_valid at rsp got %b exp 0", name, m_dmv); end
                if (e_err == 2'd1 || e_err == 2'd2) begin
                    n_tests++;
                    if (dmv != 0) begin n_fail++; $display("FAIL %s bus cycles got %0d exp 0", name, dmv); end
                end
            end else if (m_dmv) begin
                if (dmv == 0) begin
                    n_tests++;
                    if (m_addr !== e_addr || m_we !== we) begin
                        n_fail++; $display("FAIL %s bus addr/we got %h/%b exp %h/%b", name, m_addr, m_we, e_addr, we);
                    end
                    if (we) begin
                        n_tests++;
                        if (m_strb !== e_strb || m_wdata !== e_wd) begin
                            n_fail++; $display("FAIL %s wstrb/wdata got %b/%h exp %b/%h", name, m_strb, m_wdata, e_strb, e_wd);
                        end
                    end
                end
                dmv++;
                dm_ready  = (reqc >= rdly);
                dm_rvalid = 1'($urandom_range(0, 1));
                reqc++;
                if (dm_ready) hs = 1;
            end else if (hs) begin
                dm_rvalid = (waitc >= vdly);
                waitc++;
            end
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL %s no response within %0d cycles", name, cyc);
        end
        @(negedge clk);
        n_tests++;
        if (m_rspv !== 1'b0 || m_ready !== 1'b1 || m_dmv !== 1'b0) begin
            n_fail++; $display("FAIL %s after rsp valid/ready/dm_valid got %b%b%b exp 010", name, m_rspv, m_ready, m_dmv);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            sel = k[0]; #1;
            n_tests++;
            if (m_ready !== 1'b1) begin n_fail++; $display("FAIL reset req_ready inst%0d got %b exp 1", k, m_ready); end
            n_tests++;
            if ({m_dmv, m_we, m_rspv, m_strb, m_err, m_addr, m_wdata, m_rdata} !== '0) begin
                n_fail++; $display("FAIL reset outputs inst%0d got dmv%b we%b rv%b strb%b err%b addr%h wd%h rd%h exp all 0",
                                   k, m_dmv, m_we, m_rspv, m_strb, m_err, m_addr, m_wdata, m_rdata);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed32();
        txn(0, 1, 3'b010, 64'h104, 64'hDEADBEEF, 64'h0, 0, 0, "sw_104");
        txn(0, 1, 3'b000, 64'h103, 64'h000000A5, 64'h0, 0, 0, "sb_103");
        txn(0, 0, 3'b000, 64'h103, 64'h0, 64'hA5000000, 0, 0, "lb_103");
        txn(0, 0, 3'b101, 64'h102, 64'h0, 64'h80010000, 0, 0, "lhu_102");
        txn(0, 0, 3'b001, 64'h102, 64'h0, 64'h80010000, 0, 3, "lh_102_wait3");
        txn(0, 1, 3'b001, 64'h102, 64'h1234ABCD, 64'h0, 2, 0, "sh_102_stall2");
    endtask

    task automatic test_errors();
        txn(0, 0, 3'b010, 64'h101, 64'h0, 64'h0, 0, 0, "lw_misaligned");
        txn(0, 0, 3'b011, 64'h100, 64'h0, 64'h0, 0, 0, "ld_illegal32");
        txn(0, 1, 3'b100, 64'h100, 64'h0, 64'h0, 0, 0, "sbu_illegal");
        txn(0, 0, 3'b111, 64'h103, 64'h0, 64'h0, 0, 0, "op7_over_misal");
        txn(1, 0, 3'b011, 64'h0C, 64'h0, 64'h0, 0, 0, "ld_misaligned64");
    endtask

    task automatic test_timeout();
        txn(1, 1, 3'b010, 64'h10, 64'h55, 64'h0, 100, 0, "timeout_req");
        txn(1, 0, 3'b001, 64'h12, 64'h0, 64'h8000, 1, 5, "timeout_wait");
        txn(1, 1, 3'b000, 64'h11, 64'h77, 64'h0, 3, 0, "ready_at_last_cycle");
    endtask

    task automatic test_xlen64();
        txn(1, 0, 3'b011, 64'h08, 64'h0, 64'h8000_0000_0000_0001, 0, 0, "ld_08");
        txn(1, 1, 3'b011, 64'h08, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 0, "sd_08");
        txn(1, 0, 3'b110, 64'h14, 64'h0, 64'h9ABC_DEF0_1111_2222, 0, 1, "lwu_14");
        txn(1, 0, 3'b010, 64'h14, 64'h0, 64'h9ABC_DEF0_1111_2222, 0, 0, "lw_14");
    endtask

    task automatic test_reset_mid_access();
        sel = 0; #1;
        req_we = 0; req_op = 3'b010; addr64 = 64'h200; rdata64 = 64'h1234_5678; a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0; dm_ready = 1'b1;
        @(negedge clk);
        dm_ready = 1'b0;
        rst = 1'b1; #1;
        n_tests++;
        if (m_ready !== 1'b1 || {m_dmv, m_rspv, m_we, m_strb, m_err, m_addr, m_rdata} !== '0) begin
            n_fail++; $display("FAIL rst_in_wait ready%b dmv%b rv%b addr%h rd%h exp ready 1 rest 0", m_ready, m_dmv, m_rspv, m_addr, m_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        dm_rvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (m_rspv !== 1'b0 || m_ready !== 1'b1) begin
                n_fail++; $display("FAIL rst_late_rvalid cycle %0d rsp_valid %b ready %b exp 0/1", i, m_rspv, m_ready);
            end
        end
        dm_rvalid = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            bit s, we; logic [2:0] op; logic [63:0] ad, wd, rd; int rdly, vdly;
            s  = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            op = 3'($urandom_range(0, 7));
            ad = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) ad = ad & ~((64'h1 << op[1:0]) - 64'h1);
            wd = {$urandom, $urandom};
            rd = {$urandom, $urandom};
            rdly = ($urandom_range(0, 7) == 0) ? 6 : $urandom_range(0, 2);
            vdly = $urandom_range(0, 2);
            txn(s, we, op, ad, wd, rd, rdly, vdly, "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed32();
        test_errors();
        test_timeout();
        test_xlen64();
        test_reset_mid_access();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
